// File: rtl/delay_line_writer.sv
// Serial word writer for the delay-line memory: shifts a captured word LSB first onto DL31 or
// DL44, one bit per strobe, framed by SYNC. Optional parity insertion: DL_WRITER_PARITY_EN.
module delay_line_writer #(
    parameter int unsigned WORD_BITS = 28
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_bitstb,
    input  logic                 i_sync,
    input  logic                 i_load,
    input  logic [WORD_BITS-1:0] i_data,
    input  logic                 i_chsel,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_lost,
    output logic                 o_ferr,
    output logic                 o_dl31,
    output logic                 o_dl44
);

    localparam int unsigned CNT_W = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BITS - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StShift} state_e;

    state_e               r_state, w_state_d;
    logic [WORD_BITS-1:0] r_word, w_word_d, w_capture;
    logic                 r_chsel, w_chsel_d;
    logic [CNT_W-1:0]     r_count, w_count_d;
    logic                 r_busy, w_busy_d;
    logic                 r_done, w_done_d;
    logic                 r_lost, w_lost_d;
    logic                 r_ferr, w_ferr_d;
    logic                 r_dl31, r_dl44;
    logic                 w_drive, w_bit;

`ifdef DL_WRITER_PARITY_EN
    // Each 14-bit syllable carries odd parity in its top bit.
    always_comb begin
        w_capture     = i_data;
        w_capture[13] = ~(^i_data[12:0]);
        w_capture[27] = ~(^i_data[26:14]);
    end
`else
    assign w_capture = i_data;
`endif

    always_comb begin
        w_state_d = r_state;
        w_word_d  = r_word;
        w_chsel_d = r_chsel;
        w_count_d = r_count;
        w_busy_d  = r_busy;
        w_done_d  = 1'b0;
        w_lost_d  = 1'b0;
        w_ferr_d  = 1'b0;
        w_drive   = 1'b0;
        w_bit     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_load) begin
                    w_word_d  = w_capture;
                    w_chsel_d = i_chsel;
                    w_busy_d  = 1'b1;
                    w_count_d = '0;
                    w_state_d = StArmed;
                end
            end
            StArmed: begin
                w_lost_d = i_load;
                if (i_bitstb && i_sync) begin
                    w_drive   = 1'b1;
                    w_bit     = r_word[0];
                    w_count_d = CNT_W'(1);
                    w_state_d = StShift;
                end
            end
            StShift: begin
                w_lost_d = i_load;
                if (i_bitstb) begin
                    w_drive = 1'b1;
                    if (i_sync) begin
                        // Mid-word SYNC: restart the word with this strobe as bit 0.
                        w_ferr_d  = 1'b1;
                        w_bit     = r_word[0];
                        w_count_d = CNT_W'(1);
                    end else begin
                        w_bit     = r_word[r_count];
                        w_count_d = r_count + CNT_W'(1);
                        if (r_count == LAST_IDX) begin
                            w_done_d  = 1'b1;
                            w_busy_d  = 1'b0;
                            w_count_d = '0;
                            w_state_d = StIdle;
                        end
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_word  <= '0;
            r_chsel <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lost  <= 1'b0;
            r_ferr  <= 1'b0;
            r_dl31  <= 1'b1;
            r_dl44  <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_word  <= w_word_d;
            r_chsel <= w_chsel_d;
            r_count <= w_count_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
            r_lost  <= w_lost_d;
            r_ferr  <= w_ferr_d;
            // Lines are active-low: a written '1' pulls the selected line low for one cycle.
            r_dl31  <= ~(w_drive & ~r_chsel & w_bit);
            r_dl44  <= ~(w_drive & r_chsel & w_bit);
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_lost = r_lost;
    assign o_ferr = r_ferr;
    assign o_dl31 = r_dl31;
    assign o_dl44 = r_dl44;

endmodule

// File: tb/tb_delay_line_writer.sv
// Scoreboard bench for delay_line_writer: a bit-queue reference model predicts output events,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_delay_line_writer;

    localparam int unsigned WB = 28;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bitstb = 1'b0;
    logic          sync = 1'b0;
    logic          load = 1'b0;
    logic          chsel = 1'b0;
    logic [WB-1:0] data = '0;
    logic          busy, done, lost, ferr, dl31, dl44;

    delay_line_writer #(.WORD_BITS(WB)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_bitstb(bitstb),
        .i_sync  (sync),
        .i_load  (load),
        .i_data  (data),
        .i_chsel (chsel),
        .o_busy  (busy),
        .o_done  (done),
        .o_lost  (lost),
        .o_ferr  (ferr),
        .o_dl31  (dl31),
        .o_dl44  (dl44)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic dl31, dl44, done, lost, ferr, busy;
    } ev_t;

    ev_t           exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;

    // Reference model: a pending word plus a queue of bits still to be written.
    bit            m_have = 1'b0;
    logic [WB-1:0] m_word = '0;
    bit            m_ch = 1'b0;
    bit            m_bits[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WB-1:0] cap(input logic [WB-1:0] d);
        logic [WB-1:0] w;
        w = d;
`ifdef DL_WRITER_PARITY_EN
        begin
            int lo, hi;
            lo = 0;
            hi = 0;
            for (int i = 0; i < 13; i++) lo += int'(d[i]);
            for (int i = 14; i < 27; i++) hi += int'(d[i]);
            w[13] = (lo % 2 == 0);
            w[27] = (hi % 2 == 0);
        end
`endif
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs, predict its consequence, then advance to just after the edge.
    task automatic step(input bit r, input bit ld, input logic [WB-1:0] d, input bit cs,
                        input bit bs, input bit sy);
        ev_t e;
        bit  busy_before;
        bit  b;
        rst = r;
        load = ld;
        data = d;
        chsel = cs;
        bitstb = bs;
        sync = sy;
        e.cyc = cyc + 1;
        e.dl31 = 1'b1;
        e.dl44 = 1'b1;
        e.done = 1'b0;
        e.lost = 1'b0;
        e.ferr = 1'b0;
        if (r) begin
            m_have = 1'b0;
            m_bits.delete();
        end else begin
            busy_before = m_have;
            if (ld && busy_before) e.lost = 1'b1;
            if (busy_before && bs) begin
                if (sy) begin
                    if (m_bits.size() != 0) e.ferr = 1'b1;
                    m_bits.delete();
                    for (int i = 0; i < WB; i++) m_bits.push_back(m_word[i]);
                end
                if (m_bits.size() != 0) begin
                    b = m_bits.pop_front();
                    if (b) begin
                        if (m_ch) e.dl44 = 1'b0;
                        else e.dl31 = 1'b0;
                    end
                    if (m_bits.size() == 0) begin
                        e.done = 1'b1;
                        m_have = 1'b0;
                    end
                end
            end
            if (ld && !busy_before) begin
                m_have = 1'b1;
                m_word = cap(d);
                m_ch = cs;
            end
        end
        e.busy = m_have;
        if (!e.dl31 || !e.dl44 || e.done || e.lost || e.ferr) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobe(input bit sy);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, sy);
    endtask

    task automatic send_word(input logic [WB-1:0] d, input bit cs);
        step(1'b0, 1'b1, d, cs, 1'b0, 1'b0);
        check("busy_after_load", 32'(busy), 32'd1);
        idle($urandom_range(0, 2));
        strobe(1'b0);
        idle($urandom_range(0, 1));
        strobe(1'b1);
        for (int i = 1; i < WB; i++) begin
            idle($urandom_range(0, 2));
            strobe(1'b0);
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_en) begin
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missed_event cyc=%0d actual=none required dl31=%b dl44=%b done=%b lost=%b ferr=%b",
                         e.cyc, e.dl31, e.dl44, e.done, e.lost, e.ferr);
            end
            if (dl31 !== 1'b1 || dl44 !== 1'b1 || done !== 1'b0 || lost !== 1'b0 ||
                ferr !== 1'b0) begin
                total++;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    bad++;
                    $display("FAIL unexpected_output cyc=%0d actual dl31=%b dl44=%b done=%b lost=%b ferr=%b required idle",
                             cyc, dl31, dl44, done, lost, ferr);
                end else begin
                    e = exp_q.pop_front();
                    if ({dl31, dl44, done, lost, ferr, busy} !==
                        {e.dl31, e.dl44, e.done, e.lost, e.ferr, e.busy}) begin
                        bad++;
                        $display("FAIL event cyc=%0d actual=%b required=%b (dl31 dl44 done lost ferr busy)",
                                 cyc, {dl31, dl44, done, lost, ferr, busy},
                                 {e.dl31, e.dl44, e.done, e.lost, e.ferr, e.busy});
                    end
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("reset_dl31", 32'(dl31), 32'd1);
        check("reset_dl44", 32'(dl44), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_lost", 32'(lost), 32'd0);
        check("reset_ferr", 32'(ferr), 32'd0);
        mon_en = 1'b1;
        idle(2);

        send_word(28'h0000005, 1'b0);
        check("busy_after_basic", 32'(busy), 32'd0);
        idle(3);
        send_word(28'hFFFFFFF, 1'b1);
        idle(2);

        // Back-to-back: second LOAD lands in the DONE cycle.
        send_word(28'hA5A5A5A, 1'b0);
        send_word(28'h5A5A5A5, 1'b1);
        idle(2);

        // LOAD while busy is rejected and must not disturb the word in flight.
        step(1'b0, 1'b1, 28'h1234567, 1'b0, 1'b0, 1'b0);
        strobe(1'b1);
        for (int i = 1; i < WB; i++) begin
            if (i == 4) step(1'b0, 1'b1, 28'hFFFFFFF, 1'b1, 1'b1, 1'b0);
            else strobe(1'b0);
            if (i == 9) step(1'b0, 1'b1, 28'h0F0F0F0, 1'b1, 1'b0, 1'b0);
        end
        idle(2);

        // Framing error at bit 10: word restarts from that strobe.
        step(1'b0, 1'b1, 28'hC3C3C3F, 1'b0, 1'b0, 1'b0);
        strobe(1'b1);
        for (int i = 1; i < 10; i++) strobe(1'b0);
        strobe(1'b1);
        for (int i = 1; i < WB; i++) strobe(1'b0);
        idle(2);

        send_word(28'h0000001, 1'b0);
        idle(2);

        // Mid-word reset aborts with no DONE.
        step(1'b0, 1'b1, 28'hFFFFFFF, 1'b1, 1'b0, 1'b0);
        strobe(1'b1);
        for (int i = 0; i < 5; i++) strobe(1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("midrst_dl44", 32'(dl44), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        idle(3);

        for (int n = 0; n < 4000; n++) begin
            bit r, ld, bs, sy, cs;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 1) == 1);
            sy = bs && ($urandom_range(0, 11) == 0);
            cs = $urandom_range(0, 1) == 1;
            step(r, ld, WB'($urandom), cs, bs, sy);
        end
        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
